tcp_handshake_initiator: RTL
============================

# tcp_handshake_initiator

Client-side TCP three-way-handshake engine for one flow at a time. It takes an open request from the application side and emits a SYN on the TCP→parser tx header interface. It matches the returning SYN-ACK on the parser→TCP rx header interface, then emits the final ACK and reports the outcome. It is the peer-side counterpart of the handshake responder, and serves both as a traffic source for the responder and as the active-open path of the stack.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000: cycles to wait for a SYN-ACK before retransmitting the SYN.
- MAX_RETRIES, 3: number of SYN retransmissions allowed before reporting a timeout.
- WINDOW, 16'hFFFF: advertised window in every emitted header.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- app_init_val / app_init_rdy  in / out  1 / 1  open-request handshake.
- app_init_src_ip, app_init_dst_ip  in  `IP_ADDR_WIDTH  local and remote IP.
- app_init_src_port, app_init_dst_port  in  16  local and remote port.
- app_init_isn  in  32  local initial sequence number.
- tcp_parser_tx_val / parser_tcp_tx_rdy  out / in  1 / 1  tx header handshake.
- tcp_parser_tx_src_ip, tcp_parser_tx_dst_ip  out  `IP_ADDR_WIDTH.
- tcp_parser_tx_tcp_hdr  out  `TCP_HEADER_WIDTH  outgoing header.
- tcp_parser_tx_payload_addr  out  `PAYLOAD_BUF_ENTRY_ADDR_WIDTH  always 0.
- tcp_parser_tx_payload_len  out  `PAYLOAD_BUF_ENTRY_LEN_WIDTH  always 0.
- parser_tcp_rx_hdr_val / tcp_parser_rx_rdy  in / out  1 / 1  rx header handshake.
- parser_tcp_rx_src_ip, parser_tcp_rx_dst_ip  in  `IP_ADDR_WIDTH.
- parser_tcp_rx_tcp_hdr  in  `TCP_HEADER_WIDTH  incoming header.
- init_done_val / init_done_rdy  out / in  1 / 1  completion handshake.
- init_done_status  out  2  completion code: 0 = OK, 1 = REFUSED (RST), 2 = TIMEOUT.
- init_done_remote_isn  out  32  peer ISN; valid only when status is OK, otherwise 0.

## Operation
- Header layout (160 bits, MSB first):
  - src_port [159:144], dst_port [143:128], seq [127:96], ack [95:64].
  - data offset [63:60], always 5.
  - flags [56:48]: FIN 48, SYN 49, RST 50, PSH 51, ACK 52.
  - window [47:32]; checksum [31:16] and urgent pointer [15:0] are emitted as 0 (checksum is filled downstream).
- States:
  - IDLE: app_init_rdy=1. A request is captured on val&&rdy, retry count is cleared, next state SEND_SYN.
  - SEND_SYN: tx_val=1 with seq=isn, ack=0, flags=SYN. On tx handshake → WAIT_SYNACK with the timer cleared.
  - WAIT_SYNACK: timer increments each cycle. A matching header is handled as follows:
    - SYN=1, ACK=1, ack field = isn+1 (mod 2^32): store seq as remote ISN → SEND_ACK.
    - RST=1, ACK=1, ack field = isn+1: → REPORT with REFUSED.
    - Anything else: dropped; timer keeps running.
  - Timer expiry (timer == TIMEOUT_CYCLES-1):
    - retry count < MAX_RETRIES: increment retry count → SEND_SYN, resending the identical SYN.
    - otherwise: → REPORT with TIMEOUT.
  - SEND_ACK: tx_val=1 with seq=isn+1, ack=remote_isn+1, flags=ACK. On tx handshake → REPORT with OK.
  - REPORT: init_done_val=1. On init_done_rdy → IDLE.
- A header "matches" when rx src_ip = captured dst_ip, rx dst_ip = captured src_ip, rx src_port = dst_port and rx dst_port = src_port.
- tcp_parser_rx_rdy is 1 in every state after reset. Headers arriving outside WAIT_SYNACK, or not matching, are consumed and discarded.

## Timing
- Reset values: all registers 0 and state IDLE.
  - app_init_rdy=1.
  - tcp_parser_tx_val=0 and init_done_val=0; all data outputs 0.
  - tcp_parser_rx_rdy=1 from the first cycle after deassertion.
- Request accepted in cycle N → SYN valid in cycle N+1.
- SYN-ACK accepted in cycle M → ACK valid in cycle M+1.
- ACK handshake in cycle K → init_done_val in cycle K+1.
- tx and done outputs are registered and held stable while val && !rdy.
- If a matching SYN-ACK arrives in the same cycle the timer expires, the SYN-ACK wins: no retransmit occurs.
- Timer counts from 0 on entry to WAIT_SYNACK, so expiry occurs TIMEOUT_CYCLES cycles after the SYN handshake.
- All sequence arithmetic wraps modulo 2^32.
- Asserting rst_n low mid-handshake aborts the flow immediately. No completion is reported for the aborted request.

## Structure
- Shared package tcp_hs_pkg holds:
  - header field offsets and flag bit indices;
  - the state enum (IDLE, SEND_SYN, WAIT_SYNACK, SEND_ACK, REPORT);
  - the status enum (OK, REFUSED, TIMEOUT);
  - a header-pack function used by both this block and the responder.
- No sub-module is needed; the FSM, tuple registers, timer and retry counter all live in one module.

## Test plan
- Basic open: request 10.0.0.1:1000 → 10.0.0.2:80 with isn 0x100.
  - SYN emitted with seq 0x100 and flags 0x002.
  - Reply SYN-ACK seq 0x5000, ack 0x101 → ACK emitted with seq 0x101, ack 0x5001.
  - Completion reports status 0 and remote_isn 0x5000.
- Refused: reply RST|ACK with ack 0x101 → status 1, no ACK emitted.
- Timeout: TIMEOUT_CYCLES=20, MAX_RETRIES=2, no reply → 3 identical SYNs ~20 cycles apart, then status 2.
- Filtering: send a SYN-ACK from the wrong port, then one with ack 0x200 → both consumed and dropped. A subsequent correct SYN-ACK completes the handshake normally.
- Backpressure and wrap: hold parser_tcp_tx_rdy low for 5 cycles while the SYN is pending.
  - tx data must stay stable.
  - Use isn 0xFFFFFFFF → expected SYN-ACK ack is 0x0; ACK carries seq 0x0.
- Reset mid-handshake: rst_n low in WAIT_SYNACK → all outputs return to reset values. A new request after reset works normally.

Source files
------------

// File: rtl/tcp_hs_pkg.sv
// Shared TCP handshake definitions: header layout, FSM/status encodings and header packing.
// Used by both the handshake initiator and the responder.
package tcp_hs_pkg;

    localparam int IP_ADDR_WIDTH                = 32;
    localparam int TCP_HEADER_WIDTH             = 160;
    localparam int PAYLOAD_BUF_ENTRY_ADDR_WIDTH = 12;
    localparam int PAYLOAD_BUF_ENTRY_LEN_WIDTH  = 16;

    localparam int HDR_SRC_PORT_LSB = 144;
    localparam int HDR_DST_PORT_LSB = 128;
    localparam int HDR_SEQ_LSB      = 96;
    localparam int HDR_ACK_LSB      = 64;
    localparam int HDR_DOFF_LSB     = 60;
    localparam int HDR_FLAGS_LSB    = 48;
    localparam int HDR_WINDOW_LSB   = 32;

    // Flag bit indices relative to the 9-bit flags field.
    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;

    localparam logic [8:0] FLAGS_SYN = 9'h002;
    localparam logic [8:0] FLAGS_ACK = 9'h010;
    localparam logic [3:0] DATA_OFFSET = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_SYN,
        ST_WAIT_SYNACK,
        ST_SEND_ACK,
        ST_REPORT
    } hs_state_e;

    typedef enum logic [1:0] {
        HS_OK      = 2'd0,
        HS_REFUSED = 2'd1,
        HS_TIMEOUT = 2'd2
    } hs_status_e;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [3:0]  doff;
        logic [2:0]  rsvd;
        logic [8:0]  flags;
        logic [15:0] window;
        logic [15:0] checksum;
        logic [15:0] urgent;
    } tcp_hdr_t;

    // Checksum is left zero; it is filled in downstream.
    function automatic logic [TCP_HEADER_WIDTH-1:0] tcp_hdr_pack(
        input logic [15:0] src_port,
        input logic [15:0] dst_port,
        input logic [31:0] seq,
        input logic [31:0] ack,
        input logic [8:0]  flags,
        input logic [15:0] window
    );
        tcp_hdr_t h;
        h          = '0;
        h.src_port = src_port;
        h.dst_port = dst_port;
        h.seq      = seq;
        h.ack      = ack;
        h.doff     = DATA_OFFSET;
        h.flags    = flags;
        h.window   = window;
        return h;
    endfunction

endpackage

// File: rtl/tcp_handshake_initiator_if.sv
// Application, tx-header, rx-header and completion channels of the handshake initiator.
// master = the initiator, slave = its environment (application + parser).
interface tcp_handshake_initiator_if;
    import tcp_hs_pkg::*;

    logic                                    app_init_val;
    logic                                    app_init_rdy;
    logic [IP_ADDR_WIDTH-1:0]                app_init_src_ip;
    logic [IP_ADDR_WIDTH-1:0]                app_init_dst_ip;
    logic [15:0]                             app_init_src_port;
    logic [15:0]                             app_init_dst_port;
    logic [31:0]                             app_init_isn;

    logic                                    tcp_parser_tx_val;
    logic                                    parser_tcp_tx_rdy;
    logic [IP_ADDR_WIDTH-1:0]                tcp_parser_tx_src_ip;
    logic [IP_ADDR_WIDTH-1:0]                tcp_parser_tx_dst_ip;
    logic [TCP_HEADER_WIDTH-1:0]             tcp_parser_tx_tcp_hdr;
    logic [PAYLOAD_BUF_ENTRY_ADDR_WIDTH-1:0] tcp_parser_tx_payload_addr;
    logic [PAYLOAD_BUF_ENTRY_LEN_WIDTH-1:0]  tcp_parser_tx_payload_len;

    logic                                    parser_tcp_rx_hdr_val;
    logic                                    tcp_parser_rx_rdy;
    logic [IP_ADDR_WIDTH-1:0]                parser_tcp_rx_src_ip;
    logic [IP_ADDR_WIDTH-1:0]                parser_tcp_rx_dst_ip;
    logic [TCP_HEADER_WIDTH-1:0]             parser_tcp_rx_tcp_hdr;

    logic                                    init_done_val;
    logic                                    init_done_rdy;
    logic [1:0]                              init_done_status;
    logic [31:0]                             init_done_remote_isn;

    modport master (
        input  app_init_val, app_init_src_ip, app_init_dst_ip,
               app_init_src_port, app_init_dst_port, app_init_isn,
        output app_init_rdy,
        output tcp_parser_tx_val, tcp_parser_tx_src_ip, tcp_parser_tx_dst_ip,
               tcp_parser_tx_tcp_hdr, tcp_parser_tx_payload_addr, tcp_parser_tx_payload_len,
        input  parser_tcp_tx_rdy,
        input  parser_tcp_rx_hdr_val, parser_tcp_rx_src_ip, parser_tcp_rx_dst_ip,
               parser_tcp_rx_tcp_hdr,
        output tcp_parser_rx_rdy,
        output init_done_val, init_done_status, init_done_remote_isn,
        input  init_done_rdy
    );

    modport slave (
        output app_init_val, app_init_src_ip, app_init_dst_ip,
               app_init_src_port, app_init_dst_port, app_init_isn,
        input  app_init_rdy,
        input  tcp_parser_tx_val, tcp_parser_tx_src_ip, tcp_parser_tx_dst_ip,
               tcp_parser_tx_tcp_hdr, tcp_parser_tx_payload_addr, tcp_parser_tx_payload_len,
        output parser_tcp_tx_rdy,
        output parser_tcp_rx_hdr_val, parser_tcp_rx_src_ip, parser_tcp_rx_dst_ip,
               parser_tcp_rx_tcp_hdr,
        input  tcp_parser_rx_rdy,
        input  init_done_val, init_done_status, init_done_remote_isn,
        output init_done_rdy
    );

endinterface

// File: rtl/tcp_handshake_initiator.sv
// Client-side TCP three-way handshake: SYN out, SYN-ACK/RST in, final ACK out, outcome reported.
// One flow at a time; SYN is retransmitted on timeout up to MAX_RETRIES times.
module tcp_handshake_initiator
    import tcp_hs_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          MAX_RETRIES    = 3,
    parameter logic [15:0] WINDOW         = 16'hFFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tcp_handshake_initiator_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    hs_state_e                   state_q, state_d;
    logic [IP_ADDR_WIDTH-1:0]    src_ip_q, src_ip_d;
    logic [IP_ADDR_WIDTH-1:0]    dst_ip_q, dst_ip_d;
    logic [15:0]                 src_port_q, src_port_d;
    logic [15:0]                 dst_port_q, dst_port_d;
    logic [31:0]                 isn_q, isn_d;
    logic [31:0]                 remote_isn_q, remote_isn_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [RW-1:0]               retry_q, retry_d;
    logic                        tx_val_q, tx_val_d;
    logic [TCP_HEADER_WIDTH-1:0] tx_hdr_q, tx_hdr_d;
    logic                        rx_rdy_q, rx_rdy_d;
    logic                        done_val_q, done_val_d;
    hs_status_e                  status_q, status_d;
    logic [31:0]                 done_isn_q, done_isn_d;

    tcp_hdr_t    rx_hdr;
    logic        rx_match;
    logic        rx_ack_ok;
    logic        rx_synack;
    logic        rx_rstack;
    logic [31:0] isn_p1;

    assign rx_hdr = bus.parser_tcp_rx_tcp_hdr;
    assign isn_p1 = isn_q + 32'd1;

    // Every accepted header is consumed; only matching ones in WAIT_SYNACK have an effect.
    assign rx_match = bus.parser_tcp_rx_hdr_val && rx_rdy_q &&
                      (bus.parser_tcp_rx_src_ip == dst_ip_q) &&
                      (bus.parser_tcp_rx_dst_ip == src_ip_q) &&
                      (rx_hdr.src_port == dst_port_q) &&
                      (rx_hdr.dst_port == src_port_q);
    assign rx_ack_ok = rx_match && rx_hdr.flags[FLAG_ACK] && (rx_hdr.ack == isn_p1);
    assign rx_synack = rx_ack_ok && rx_hdr.flags[FLAG_SYN];
    assign rx_rstack = rx_ack_ok && rx_hdr.flags[FLAG_RST];

    always_comb begin
        state_d      = state_q;
        src_ip_d     = src_ip_q;
        dst_ip_d     = dst_ip_q;
        src_port_d   = src_port_q;
        dst_port_d   = dst_port_q;
        isn_d        = isn_q;
        remote_isn_d = remote_isn_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        tx_val_d     = tx_val_q;
        tx_hdr_d     = tx_hdr_q;
        rx_rdy_d     = 1'b1;
        done_val_d   = done_val_q;
        status_d     = status_q;
        done_isn_d   = done_isn_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.app_init_val) begin
                    src_ip_d   = bus.app_init_src_ip;
                    dst_ip_d   = bus.app_init_dst_ip;
                    src_port_d = bus.app_init_src_port;
                    dst_port_d = bus.app_init_dst_port;
                    isn_d      = bus.app_init_isn;
                    retry_d    = '0;
                    tx_val_d   = 1'b1;
                    tx_hdr_d   = tcp_hdr_pack(bus.app_init_src_port, bus.app_init_dst_port,
                                              bus.app_init_isn, 32'd0, FLAGS_SYN, WINDOW);
                    state_d    = ST_SEND_SYN;
                end
            end
            ST_SEND_SYN: begin
                if (bus.parser_tcp_tx_rdy) begin
                    tx_val_d = 1'b0;
                    timer_d  = '0;
                    state_d  = ST_WAIT_SYNACK;
                end
            end
            ST_WAIT_SYNACK: begin
                timer_d = timer_q + 1'b1;
                // A SYN-ACK landing on the expiry cycle takes priority over the retransmit.
                if (rx_synack) begin
                    remote_isn_d = rx_hdr.seq;
                    tx_val_d     = 1'b1;
                    tx_hdr_d     = tcp_hdr_pack(src_port_q, dst_port_q, isn_p1,
                                                rx_hdr.seq + 32'd1, FLAGS_ACK, WINDOW);
                    state_d      = ST_SEND_ACK;
                end else if (rx_rstack) begin
                    done_val_d = 1'b1;
                    status_d   = HS_REFUSED;
                    done_isn_d = '0;
                    state_d    = ST_REPORT;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d  = retry_q + 1'b1;
                        tx_val_d = 1'b1;
                        state_d  = ST_SEND_SYN;
                    end else begin
                        done_val_d = 1'b1;
                        status_d   = HS_TIMEOUT;
                        done_isn_d = '0;
                        state_d    = ST_REPORT;
                    end
                end
            end
            ST_SEND_ACK: begin
                if (bus.parser_tcp_tx_rdy) begin
                    tx_val_d   = 1'b0;
                    done_val_d = 1'b1;
                    status_d   = HS_OK;
                    done_isn_d = remote_isn_q;
                    state_d    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (bus.init_done_rdy) begin
                    done_val_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            src_ip_q     <= '0;
            dst_ip_q     <= '0;
            src_port_q   <= '0;
            dst_port_q   <= '0;
            isn_q        <= '0;
            remote_isn_q <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            tx_val_q     <= 1'b0;
            tx_hdr_q     <= '0;
            rx_rdy_q     <= 1'b0;
            done_val_q   <= 1'b0;
            status_q     <= HS_OK;
            done_isn_q   <= '0;
        end else begin
            state_q      <= state_d;
            src_ip_q     <= src_ip_d;
            dst_ip_q     <= dst_ip_d;
            src_port_q   <= src_port_d;
            dst_port_q   <= dst_port_d;
            isn_q        <= isn_d;
            remote_isn_q <= remote_isn_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            tx_val_q     <= tx_val_d;
            tx_hdr_q     <= tx_hdr_d;
            rx_rdy_q     <= rx_rdy_d;
            done_val_q   <= done_val_d;
            status_q     <= status_d;
            done_isn_q   <= done_isn_d;
        end
    end

    assign bus.app_init_rdy               = (state_q == ST_IDLE);
    assign bus.tcp_parser_tx_val          = tx_val_q;
    assign bus.tcp_parser_tx_src_ip       = src_ip_q;
    assign bus.tcp_parser_tx_dst_ip       = dst_ip_q;
    assign bus.tcp_parser_tx_tcp_hdr      = tx_hdr_q;
    assign bus.tcp_parser_tx_payload_addr = '0;
    assign bus.tcp_parser_tx_payload_len  = '0;
    assign bus.tcp_parser_rx_rdy          = rx_rdy_q;
    assign bus.init_done_val              = done_val_q;
    assign bus.init_done_status           = status_q;
    assign bus.init_done_remote_isn       = done_isn_q;

endmodule
